// File: rtl/rf_pkg.sv
// Shared types and sizing for the scalar register-file write-port controller.
package rf_pkg;

    localparam int NREGS  = 12;
    localparam int AW     = 4;
    localparam int DW     = 16;
    localparam int NSLOTS = 1 << AW;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] reg_data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    function automatic logic in_range(reg_addr_t a);
        return int'(a) < NREGS;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester that
// wins a tie and flips to the loser after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic r_ptr;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (advance) begin
            r_ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-port controller for the 12 x 16 scalar register file: arbitrates ALU and
// load writeback, registers the write by one cycle and tracks pending writes.
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    output logic             iss_ready,
    input  logic             rd_use1,
    input  logic             rd_use2,
    input  logic [AW-1:0]    rd_a1,
    input  logic [AW-1:0]    rd_a2,
    output logic             raw_stall,
    input  logic [1:0]       wb_valid,
    input  logic [AW-1:0]    wb_addr0,
    input  logic [AW-1:0]    wb_addr1,
    input  logic [DW-1:0]    wb_data0,
    input  logic [DW-1:0]    wb_data1,
    output logic [1:0]       wb_ready,
    output logic             rf_wre,
    output logic [AW-1:0]    rf_a3,
    output logic [DW-1:0]    rf_wd3,
    output logic [NREGS-1:0] busy,
    output logic             addr_err
);

    wb_req_t              w_req0;
    wb_req_t              w_req1;
    wb_req_t              w_sel;
    logic [1:0]           w_gnt;
    logic                 w_xfer;
    logic                 w_iss_acc;
    logic [NSLOTS-1:0]    w_busy_ext;
    logic [NREGS-1:0]     w_set;
    logic [NREGS-1:0]     w_clr;

    logic [NREGS-1:0]     r_busy;
    logic                 r_wre;
    reg_addr_t            r_a3;
    reg_data_t            r_wd3;
    logic                 r_err;

    assign w_req0 = '{valid: wb_valid[0], addr: wb_addr0, data: wb_data0};
    assign w_req1 = '{valid: wb_valid[1], addr: wb_addr1, data: wb_data1};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wb_valid),
        .advance (w_xfer),
        .gnt     (w_gnt)
    );

    // No handshake completes while reset is high, so held requests are re-arbitrated afterwards.
    assign wb_ready = rst ? 2'b00 : w_gnt;
    assign w_xfer   = |wb_ready;
    assign w_sel    = wb_ready[1] ? w_req1 : w_req0;

    // Padding the scoreboard to every encodable index makes out-of-range lookups read as free.
    assign w_busy_ext = {{(NSLOTS - NREGS){1'b0}}, r_busy};
    assign iss_ready  = ~w_busy_ext[iss_rd];
    assign raw_stall  = (rd_use1 & w_busy_ext[rd_a1]) | (rd_use2 & w_busy_ext[rd_a2]);
    assign w_iss_acc  = iss_valid & iss_ready;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_iss_acc && in_range(iss_rd)) begin
            w_set = {{(NREGS - 1){1'b0}}, 1'b1} << iss_rd;
        end
        if (r_wre) begin
            w_clr = {{(NREGS - 1){1'b0}}, 1'b1} << r_a3;
        end
    end

    // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_wre  <= 1'b0;
            r_a3   <= '0;
            r_wd3  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
            r_wre  <= w_xfer & w_sel.valid & in_range(w_sel.addr);
            if (w_xfer) begin
                r_a3  <= w_sel.addr;
                r_wd3 <= w_sel.data;
            end
            if ((w_xfer && !in_range(w_sel.addr)) || (w_iss_acc && !in_range(iss_rd))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rf_wre   = r_wre;
    assign rf_a3    = r_a3;
    assign rf_wd3   = r_wd3;
    assign busy     = r_busy;
    assign addr_err = r_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: each task drives one scenario and checks
// hand-computed values; inputs change at posedge+1, outputs are read at posedge+2.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic             clk;
    logic             rst;
    logic             iss_valid;
    logic [AW-1:0]    iss_rd;
    logic             iss_ready;
    logic             rd_use1;
    logic             rd_use2;
    logic [AW-1:0]    rd_a1;
    logic [AW-1:0]    rd_a2;
    logic             raw_stall;
    logic [1:0]       wb_valid;
    logic [AW-1:0]    wb_addr0;
    logic [AW-1:0]    wb_addr1;
    logic [DW-1:0]    wb_data0;
    logic [DW-1:0]    wb_data1;
    logic [1:0]       wb_ready;
    logic             rf_wre;
    logic [AW-1:0]    rf_a3;
    logic [DW-1:0]    rf_wd3;
    logic [NREGS-1:0] busy;
    logic             addr_err;

    int n_total = 0;
    int n_pass  = 0;

    rf_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rd_use1   (rd_use1),
        .rd_use2   (rd_use2),
        .rd_a1     (rd_a1),
        .rd_a2     (rd_a2),
        .raw_stall (raw_stall),
        .wb_valid  (wb_valid),
        .wb_addr0  (wb_addr0),
        .wb_addr1  (wb_addr1),
        .wb_data0  (wb_data0),
        .wb_data1  (wb_data1),
        .wb_ready  (wb_ready),
        .rf_wre    (rf_wre),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3),
        .busy      (busy),
        .addr_err  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        iss_valid = 1'b0; iss_rd = '0;
        rd_use1 = 1'b0; rd_use2 = 1'b0; rd_a1 = '0; rd_a2 = '0;
        wb_valid = 2'b00; wb_addr0 = '0; wb_addr1 = '0; wb_data0 = '0; wb_data1 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_total++;
        if (busy !== 12'h000) $display("FAIL reset_busy: got %h want 000", busy);
        else n_pass++;
        n_total++;
        if ({rf_wre, iss_ready, raw_stall, addr_err, wb_ready} !== 6'b010000)
            $display("FAIL reset_flags: got wre=%b iss_ready=%b raw=%b err=%b ready=%b want 0 1 0 0 00",
                     rf_wre, iss_ready, raw_stall, addr_err, wb_ready);
        else n_pass++;
        tick();
        n_total++;
        if ({rf_wre, busy} !== 13'h0) $display("FAIL idle_after_reset: wre=%b busy=%h want 0 000", rf_wre, busy);
        else n_pass++;
    endtask

    task automatic test_issue_write();
        iss_valid = 1'b1; iss_rd = 4'd5;
        #1;
        n_total++;
        if (iss_ready !== 1'b1) $display("FAIL issue5_ready: got %b want 1", iss_ready);
        else n_pass++;
        tick();
        iss_valid = 1'b0;
        rd_use1 = 1'b1; rd_a1 = 4'd5;
        wb_valid = 2'b01; wb_addr0 = 4'd5; wb_data0 = 16'hBEEF;
        #1;
        n_total++;
        if (busy !== 12'h020) $display("FAIL busy5_set: got %h want 020", busy);
        else n_pass++;
        n_total++;
        if ({raw_stall, wb_ready, rf_wre} !== 4'b1010)
            $display("FAIL raw5_grant: raw=%b ready=%b wre=%b want 1 01 0", raw_stall, wb_ready, rf_wre);
        else n_pass++;
        tick();
        wb_valid = 2'b00;
        #1;
        n_total++;
        if ({rf_wre, rf_a3, rf_wd3} !== {1'b1, 4'd5, 16'hBEEF})
            $display("FAIL write5_port: wre=%b a3=%0d wd3=%h want 1 5 beef", rf_wre, rf_a3, rf_wd3);
        else n_pass++;
        n_total++;
        if ({busy[5], raw_stall} !== 2'b11)
            $display("FAIL busy5_commit_cycle: busy5=%b raw=%b want 1 1", busy[5], raw_stall);
        else n_pass++;
        tick();
        n_total++;
        if ({busy, raw_stall, rf_wre} !== 14'h0)
            $display("FAIL busy5_cleared: busy=%h raw=%b wre=%b want 000 0 0", busy, raw_stall, rf_wre);
        else n_pass++;
        rd_use1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a0, a1, exp_a3;
        logic [DW-1:0] exp_wd;
        logic [1:0]    exp_g;
        do_reset();
        a0 = 4'd1; a1 = 4'd2; exp_a3 = '0; exp_wd = '0;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 2'b11;
            wb_addr0 = a0; wb_data0 = 16'h1000 + 16'(a0);
            wb_addr1 = a1; wb_data1 = 16'h2000 + 16'(a1);
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_total++;
            if (wb_ready !== exp_g) $display("FAIL rr_grant[%0d]: got %b want %b", i, wb_ready, exp_g);
            else n_pass++;
            n_total++;
            if (i == 0) begin
                if (rf_wre !== 1'b0) $display("FAIL rr_first_wre: got %b want 0", rf_wre);
                else n_pass++;
            end else begin
                if ({rf_wre, rf_a3, rf_wd3} !== {1'b1, exp_a3, exp_wd})
                    $display("FAIL rr_write[%0d]: wre=%b a3=%0d wd3=%h want 1 %0d %h",
                             i, rf_wre, rf_a3, rf_wd3, exp_a3, exp_wd);
                else n_pass++;
            end
            if (exp_g[0]) begin
                exp_a3 = a0; exp_wd = 16'h1000 + 16'(a0); a0 = a0 + 4'd2;
            end else begin
                exp_a3 = a1; exp_wd = 16'h2000 + 16'(a1); a1 = a1 + 4'd2;
            end
            tick();
        end
        wb_valid = 2'b00;
        #1;
        n_total++;
        if ({rf_wre, rf_a3, rf_wd3} !== {1'b1, 4'd4, 16'h2004})
            $display("FAIL rr_last_write: wre=%b a3=%0d wd3=%h want 1 4 2004", rf_wre, rf_a3, rf_wd3);
        else n_pass++;
        tick();
        n_total++;
        if ({rf_wre, busy} !== 13'h0) $display("FAIL rr_drain: wre=%b busy=%h want 0 000", rf_wre, busy);
        else n_pass++;
    endtask

    task automatic test_waw_stall();
        iss_valid = 1'b1; iss_rd = 4'd3;
        #1;
        n_total++;
        if (iss_ready !== 1'b1) $display("FAIL waw_first_issue: got %b want 1", iss_ready);
        else n_pass++;
        tick();
        wb_valid = 2'b01; wb_addr0 = 4'd3; wb_data0 = 16'h3333;
        #1;
        n_total++;
        if ({busy, iss_ready, wb_ready} !== {12'h008, 1'b0, 2'b01})
            $display("FAIL waw_stall: busy=%h iss_ready=%b ready=%b want 008 0 01", busy, iss_ready, wb_ready);
        else n_pass++;
        tick();
        wb_valid = 2'b00;
        #1;
        n_total++;
        if ({iss_ready, rf_wre, rf_a3} !== {1'b0, 1'b1, 4'd3})
            $display("FAIL waw_commit: iss_ready=%b wre=%b a3=%0d want 0 1 3", iss_ready, rf_wre, rf_a3);
        else n_pass++;
        tick();
        n_total++;
        if (iss_ready !== 1'b1) $display("FAIL waw_release: got %b want 1", iss_ready);
        else n_pass++;
        tick();
        iss_valid = 1'b0;
        rd_use1 = 1'b1; rd_a1 = 4'd13; rd_use2 = 1'b1; rd_a2 = 4'd15;
        #1;
        n_total++;
        if ({busy, raw_stall} !== {12'h008, 1'b0})
            $display("FAIL waw_reissue_oor_src: busy=%h raw=%b want 008 0", busy, raw_stall);
        else n_pass++;
        rd_a2 = 4'd3;
        #1;
        n_total++;
        if (raw_stall !== 1'b1) $display("FAIL raw_src2: got %b want 1", raw_stall);
        else n_pass++;
        rd_use2 = 1'b0;
        #1;
        n_total++;
        if (raw_stall !== 1'b0) $display("FAIL raw_src2_unused: got %b want 0", raw_stall);
        else n_pass++;
        rd_use1 = 1'b0;
    endtask

    task automatic test_addr_err();
        iss_valid = 1'b1; iss_rd = 4'd14;
        #1;
        n_total++;
        if ({iss_ready, addr_err} !== 2'b10)
            $display("FAIL oor_issue_ready: iss_ready=%b err=%b want 1 0", iss_ready, addr_err);
        else n_pass++;
        tick();
        iss_valid = 1'b0;
        #1;
        n_total++;
        if ({addr_err, busy} !== {1'b1, 12'h008})
            $display("FAIL oor_issue_err: err=%b busy=%h want 1 008", addr_err, busy);
        else n_pass++;
        do_reset();
        wb_valid = 2'b10; wb_addr1 = 4'd13; wb_data1 = 16'hDEAD;
        #1;
        n_total++;
        if ({wb_ready, addr_err} !== 3'b100)
            $display("FAIL oor_write_grant: ready=%b err=%b want 10 0", wb_ready, addr_err);
        else n_pass++;
        tick();
        wb_valid = 2'b00;
        #1;
        n_total++;
        if ({rf_wre, addr_err, busy} !== {1'b0, 1'b1, 12'h000})
            $display("FAIL oor_write_effect: wre=%b err=%b busy=%h want 0 1 000", rf_wre, addr_err, busy);
        else n_pass++;
        tick();
        tick();
        tick();
        n_total++;
        if (addr_err !== 1'b1) $display("FAIL addr_err_sticky: got %b want 1", addr_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        wb_valid = 2'b01; wb_addr0 = 4'd0; wb_data0 = 16'h0000;
        iss_valid = 1'b1; iss_rd = 4'd4;
        tick();
        wb_valid = 2'b00;
        iss_rd = 4'd7;
        tick();
        iss_valid = 1'b0;
        #1;
        n_total++;
        if (busy !== 12'h090) $display("FAIL mid_busy_setup: got %h want 090", busy);
        else n_pass++;
        wb_valid = 2'b11;
        wb_addr0 = 4'd6; wb_data0 = 16'h6666;
        wb_addr1 = 4'd9; wb_data1 = 16'h9999;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_total++;
        if ({busy, rf_wre, addr_err} !== 14'h0)
            $display("FAIL mid_reset_state: busy=%h wre=%b err=%b want 000 0 0", busy, rf_wre, addr_err);
        else n_pass++;
        n_total++;
        if (wb_ready !== 2'b01) $display("FAIL mid_reset_first_grant: got %b want 01", wb_ready);
        else n_pass++;
        tick();
        wb_addr0 = 4'd8; wb_data0 = 16'h8888;
        #1;
        n_total++;
        if ({wb_ready, rf_wre, rf_a3, rf_wd3} !== {2'b10, 1'b1, 4'd6, 16'h6666})
            $display("FAIL mid_second_grant: ready=%b wre=%b a3=%0d wd3=%h want 10 1 6 6666",
                     wb_ready, rf_wre, rf_a3, rf_wd3);
        else n_pass++;
        tick();
        wb_valid = 2'b00;
        #1;
        n_total++;
        if ({rf_wre, rf_a3, rf_wd3} !== {1'b1, 4'd9, 16'h9999})
            $display("FAIL mid_mem_write: wre=%b a3=%0d wd3=%h want 1 9 9999", rf_wre, rf_a3, rf_wd3);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_issue_write();
        test_back_to_back();
        test_waw_stall();
        test_addr_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
